// File: rtl/memory_arbiter_if.sv
// Bundle of the two requesting masters and the synchronous Memory port around memory_arbiter.
//
// Handshake: a master raises mN_req with mN_we/mN_addr/mN_wdata stable and keeps them
// stable until it samples a one-cycle mN_ack (done) or mN_err (timeout) pulse; on that
// edge it drops req or presents its next request. Memory strobes (mem_read/mem_write)
// are single-cycle; Memory answers with the matching mem_sync_*_response pulse.
interface memory_arbiter_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_we;
    logic        m1_we;
    logic [31:0] m0_addr;
    logic [31:0] m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m0_ack;
    logic        m1_ack;
    logic        m0_err;
    logic        m1_err;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic        busy;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_sync;
    logic        mem_sync_read_response;
    logic        mem_sync_write_response;

    // Arbiter side
    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        input  mem_read_sync, mem_sync_read_response, mem_sync_write_response,
        output m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata, busy,
        output mem_read, mem_write, mem_address, mem_write_data
    );

    // Environment side: requesting masters plus the Memory block
    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata,
        output mem_read_sync, mem_sync_read_response, mem_sync_write_response,
        input  m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata, busy,
        input  mem_read, mem_write, mem_address, mem_write_data
    );
endinterface

// File: rtl/memory_arbiter.sv
// Two-master arbiter in front of the shared Memory block. Serialises word accesses into
// single-cycle read/write strobes and routes the synchronous response back as ack/err.
module memory_arbiter #(
    parameter bit ROUND_ROBIN    = 1'b0,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                reset,
    memory_arbiter_if.slave     bus,
    output logic [1:0]          state_o
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_e;

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_e        state_q, state_d;
    logic          grant_q, grant_d;
    logic          last_grant_q, last_grant_d;
    logic          we_q, we_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mem_read_q, mem_read_d;
    logic          mem_write_q, mem_write_d;
    logic          ack0_q, ack0_d, ack1_q, ack1_d;
    logic          err0_q, err0_d, err1_q, err1_d;
    logic [31:0]   rdata0_q, rdata0_d, rdata1_q, rdata1_d;

    logic          req0_eff, req1_eff;
    logic          pick;
    logic          resp_ok;

    // A master whose ack/err is on the bus this cycle is still holding the req of the
    // finished transaction; it only counts as a new request one cycle later.
    assign req0_eff = bus.m0_req & ~ack0_q & ~err0_q;
    assign req1_eff = bus.m1_req & ~ack1_q & ~err1_q;

    // Next-state, grant selection and registered-output next values
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        cnt_d        = cnt_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        err0_d       = 1'b0;
        err1_d       = 1'b0;
        rdata0_d     = rdata0_q;
        rdata1_d     = rdata1_q;
        pick         = 1'b0;
        resp_ok      = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0_eff || req1_eff) begin
                    if (req0_eff && req1_eff) begin
                        pick = ROUND_ROBIN ? ~last_grant_q : 1'b0;
                    end else begin
                        pick = req1_eff;
                    end
                    grant_d      = pick;
                    last_grant_d = pick;
                    we_d         = pick ? bus.m1_we : bus.m0_we;
                    addr_d       = (pick ? bus.m1_addr : bus.m0_addr) & 32'hFFFF_FFFC;
                    wdata_d      = pick ? bus.m1_wdata : bus.m0_wdata;
                    cnt_d        = '0;
                    // Strobe is registered here so it is high for exactly the ISSUE cycle
                    mem_read_d   = ~(pick ? bus.m1_we : bus.m0_we);
                    mem_write_d  = pick ? bus.m1_we : bus.m0_we;
                    state_d      = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT;
            end
            WAIT: begin
                resp_ok = we_q ? bus.mem_sync_write_response : bus.mem_sync_read_response;
                if (resp_ok) begin
                    ack0_d = ~grant_q;
                    ack1_d = grant_q;
                    if (!we_q) begin
                        if (grant_q) rdata1_d = bus.mem_read_sync;
                        else         rdata0_d = bus.mem_read_sync;
                    end
                    state_d = IDLE;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    err0_d  = ~grant_q;
                    err1_d  = grant_q;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transfer silently
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            err0_q       <= 1'b0;
            err1_q       <= 1'b0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            cnt_q        <= cnt_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            err0_q       <= err0_d;
            err1_q       <= err1_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

    assign bus.m0_ack         = ack0_q;
    assign bus.m1_ack         = ack1_q;
    assign bus.m0_err         = err0_q;
    assign bus.m1_err         = err1_q;
    assign bus.m0_rdata       = rdata0_q;
    assign bus.m1_rdata       = rdata1_q;
    assign bus.busy           = (state_q != IDLE);
    assign bus.mem_read       = mem_read_q;
    assign bus.mem_write      = mem_write_q;
    assign bus.mem_address    = addr_q;
    assign bus.mem_write_data = wdata_q;
    assign state_o            = state_q;
endmodule
